// File: rtl/seq_pkg.sv
// Shared types and constants for the "100" pattern transmitter and its
// golden-reference detector.
package seq_pkg;
    localparam int PAT_W = 16;
    localparam int LEN_W = 5;
    localparam int CNT_W = 8;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Lengths beyond the pattern width would index past the pattern register.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : l;
    endfunction
endpackage

// File: rtl/seq100_ref_chk.sv
// Golden "100" detector: tracks the last two emitted bits and flags/counts
// every occurrence, including overlapping and wrap-spanning ones.
module seq100_ref_chk
    import seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             x,
    input  logic             x_valid,
    output logic             exp_y,
    output logic [CNT_W-1:0] match_cnt
);

    logic [1:0] h;
    logic       hit;

    assign hit = x_valid & h[1] & ~h[0] & ~x;

    // h only moves on valid bits, so idle cycles neither add nor lose history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h         <= '0;
            exp_y     <= 1'b0;
            match_cnt <= '0;
        end else if (clr) begin
            h         <= '0;
            exp_y     <= 1'b0;
            match_cnt <= '0;
        end else begin
            exp_y <= hit;
            if (x_valid)
                h <= {h[0], x};
            if (hit && (match_cnt != '1))
                match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter (bit 0 first, optional looping) with an attached
// reference "100" detector producing the expected detection flag and count.
module seq_pattern_tx
    import seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             repeat_en,
    input  logic             stop,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic             exp_y,
    output logic [CNT_W-1:0] match_cnt
);

    state_t           state, state_next;
    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             rep_r;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last;

    assign last = ({1'b0, idx} == (len_r - LEN_W'(1)));

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_next = SEND;
                    accept     = 1'b1;
                end
            end
            SEND: begin
                if (stop || (last && !rep_r))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Stop takes priority over completion, so an aborted final bit gives no done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r <= '0;
            len_r <= '0;
            rep_r <= 1'b0;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                pat_r <= pattern;
                len_r <= clamp_len(len);
                rep_r <= repeat_en;
                idx   <= '0;
            end else if (state == SEND) begin
                done <= last && !rep_r && !stop;
                if (stop || last)
                    idx <= '0;
                else
                    idx <= idx + IDX_W'(1);
            end
        end
    end

    assign x_valid = (state == SEND);
    assign busy    = (state == SEND);
    assign x       = (state == SEND) & pat_r[idx];

    seq100_ref_chk u_ref_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .x         (x),
        .x_valid   (x_valid),
        .exp_y     (exp_y),
        .match_cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a behavioural model pushes expected
// per-cycle outputs into a queue that is popped after each clock edge.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic        repeat_en = 1'b0;
    logic        stop = 1'b0;
    logic        x, x_valid, busy, done, exp_y;
    logic [7:0]  match_cnt;

    typedef struct packed {
        logic       x;
        logic       x_valid;
        logic       busy;
        logic       done;
        logic       exp_y;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    bit          m_send = 0;
    bit          m_rep = 0;
    logic [15:0] m_pat = '0;
    int          m_len = 0;
    int          m_idx = 0;
    logic [2:0]  m_win = '0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    seq_pattern_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .repeat_en (repeat_en),
        .stop      (stop),
        .x         (x),
        .x_valid   (x_valid),
        .busy      (busy),
        .done      (done),
        .exp_y     (exp_y),
        .match_cnt (match_cnt)
    );

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Behavioural model of one rising edge; pushes the outputs expected after it.
    task automatic model_edge(input logic s_start, input logic [15:0] s_pat,
                              input logic [4:0] s_len, input logic s_rep, input logic s_stop);
        exp_t e;
        logic b;
        logic hit;
        logic fin;
        hit = 1'b0;
        fin = 1'b0;
        if (m_send) begin
            b     = m_pat[m_idx];
            m_win = {m_win[1:0], b};
            if (m_win == 3'b100) begin
                hit = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            if (s_stop) begin
                m_send = 0;
                m_idx  = 0;
            end else if (m_idx == m_len - 1) begin
                m_idx = 0;
                if (!m_rep) begin
                    m_send = 0;
                    fin    = 1'b1;
                end
            end else begin
                m_idx++;
            end
        end else if (s_start && s_len != 0) begin
            m_send = 1;
            m_pat  = s_pat;
            m_len  = (s_len > 16) ? 16 : int'(s_len);
            m_rep  = s_rep;
            m_idx  = 0;
            m_win  = '0;
            m_cnt  = 0;
        end
        e.x       = m_send ? m_pat[m_idx] : 1'b0;
        e.x_valid = m_send;
        e.busy    = m_send;
        e.done    = fin;
        e.exp_y   = hit;
        e.cnt     = 8'(m_cnt);
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic s_start, input logic [15:0] s_pat,
                                  input logic [4:0] s_len, input logic s_rep, input logic s_stop);
        exp_t e;
        @(negedge clk);
        start     = s_start;
        pattern   = s_pat;
        len       = s_len;
        repeat_en = s_rep;
        stop      = s_stop;
        model_edge(s_start, s_pat, s_len, s_rep, s_stop);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            check_output("x", {7'd0, x}, {7'd0, e.x});
            check_output("x_valid", {7'd0, x_valid}, {7'd0, e.x_valid});
            check_output("busy", {7'd0, busy}, {7'd0, e.busy});
            check_output("done", {7'd0, done}, {7'd0, e.done});
            check_output("exp_y", {7'd0, exp_y}, {7'd0, e.exp_y});
            check_output("match_cnt", match_cnt, e.cnt);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_x"}, {7'd0, x}, 8'd0);
        check_output({tag, "_x_valid"}, {7'd0, x_valid}, 8'd0);
        check_output({tag, "_busy"}, {7'd0, busy}, 8'd0);
        check_output({tag, "_done"}, {7'd0, done}, 8'd0);
        check_output({tag, "_exp_y"}, {7'd0, exp_y}, 8'd0);
        check_output({tag, "_match_cnt"}, match_cnt, 8'd0);
    endtask

    task automatic model_reset();
        m_send = 0;
        m_idx  = 0;
        m_cnt  = 0;
        m_win  = '0;
        sb.delete();
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Stream 1,0,0,1,0,0: matches flagged in cycles 4 and 7, done in 7.
        apply_stimulus(1'b1, 16'h0009, 5'd6, 1'b0, 1'b0);
        idle_cycles(7);
        check_output("case1_cnt", match_cnt, 8'd2);

        // Looping 1,0,0 stopped after nine bits.
        apply_stimulus(1'b1, 16'h0001, 5'd3, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++)
            apply_stimulus(1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 5'd0, 1'b0, 1'b1);
        check_output("case2_exp_y", {7'd0, exp_y}, 8'd1);
        idle_cycles(2);
        check_output("case2_cnt", match_cnt, 8'd3);

        // Looping 0,0,1: the only match spans the wrap.
        apply_stimulus(1'b1, 16'h0004, 5'd3, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++)
            apply_stimulus(1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 5'd0, 1'b0, 1'b1);
        idle_cycles(2);
        check_output("case3_cnt", match_cnt, 8'd1);

        // len=0 ignored; len=20 clamps to 16 bits.
        apply_stimulus(1'b1, 16'hFFFF, 5'd0, 1'b0, 1'b0);
        idle_cycles(2);
        apply_stimulus(1'b1, 16'hA5C3, 5'd20, 1'b0, 1'b0);
        idle_cycles(18);

        // A second start while busy must not recapture anything.
        apply_stimulus(1'b1, 16'h00F0, 5'd8, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'hFFFF, 5'd2, 1'b1, 1'b0);
        idle_cycles(9);

        // Stop coincident with the final bit: no done.
        apply_stimulus(1'b1, 16'h0009, 5'd4, 1'b0, 1'b0);
        idle_cycles(3);
        apply_stimulus(1'b0, 16'h0000, 5'd0, 1'b0, 1'b1);
        idle_cycles(2);

        // Counter saturation on a long looping run.
        apply_stimulus(1'b1, 16'h0001, 5'd3, 1'b1, 1'b0);
        idle_cycles(780);
        apply_stimulus(1'b0, 16'h0000, 5'd0, 1'b0, 1'b1);
        idle_cycles(1);
        check_output("sat_cnt", match_cnt, 8'd255);

        // Asynchronous reset mid-transmission, then recovery.
        apply_stimulus(1'b1, 16'h0009, 5'd6, 1'b0, 1'b0);
        idle_cycles(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);
        apply_stimulus(1'b1, 16'h0001, 5'd3, 1'b0, 1'b0);
        idle_cycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports are synchronous to the clock.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-005 pattern  input  16  bits to send, bit 0 first; captured on an accepted start.
REQ-006 len  input  5  number of bits to send; legal values 1..16, captured on an accepted start.
REQ-007 repeat_en  input  1  1 = loop the pattern until stop; captured on an accepted start.
REQ-008 stop  input  1  abort request; acted on only in SEND.
REQ-009 x  output  1  serial bit stream to the sequence detector.
REQ-010 x_valid  output  1  x carries a pattern bit this cycle.
REQ-011 busy  output  1  high while in SEND.
REQ-012 done  output  1  one-cycle pulse on normal completion.
REQ-013 exp_y  output  1  expected "100" detection flag (golden reference).
REQ-014 match_cnt  output  8  number of "100" occurrences emitted since the last accepted start.

Function
REQ-015 FSM states SHALL be exactly IDLE and SEND.
REQ-016 IDLE->SEND SHALL occur at a posedge with start=1 and len!=0; start with len=0 is ignored, no state change.
REQ-017 len>16 SHALL be clamped to 16 at capture.
REQ-018 In the cycle after start is accepted: x=pattern[0], x_valid=1, busy=1.
REQ-019 Each posedge in SEND SHALL advance the bit index by 1; x=pattern[idx] and x_valid=1 throughout SEND.
REQ-020 After the bit at idx=len-1 with repeat_en=0: go to IDLE; in the next cycle done=1 (for 1 cycle), x=0, x_valid=0, busy=0.
REQ-021 After the bit at idx=len-1 with repeat_en=1: idx wraps to 0 with no gap cycle and no done pulse.
REQ-022 stop=1 at a posedge in SEND SHALL force IDLE: the next cycle has x=0, x_valid=0, done=0.
REQ-023 If stop and the final-bit transition coincide, stop SHALL win: no done pulse.
REQ-024 start asserted in SEND SHALL be ignored; pattern, len and repeat_en are not recaptured.
REQ-025 The history register h[1:0] (h[0] = previous bit, h[1] = the bit before that) SHALL shift in x at each posedge where x_valid=1.
REQ-026 h SHALL be cleared on an accepted start, and SHALL persist across repeat wrap so that overlapping and wrapping occurrences count.
REQ-027 exp_y is registered: exp_y <= x_valid & h[1] & ~h[0] & ~x; it is high for exactly the one cycle after the final 0 of a "100" occurrence is on x.
REQ-028 match_cnt SHALL increment on the same posedge that sets exp_y, saturate at 255, and clear to 0 on an accepted start.
REQ-029 exp_y and match_cnt SHALL NOT change in IDLE, except for the final exp_y update for the last emitted bit.

Reset
REQ-030 rst_n=0 SHALL immediately force: IDLE, x=0, x_valid=0, busy=0, done=0, exp_y=0, match_cnt=0, h=0, idx=0.
REQ-031 Reset asserted mid-transmission SHALL abort it with no done pulse; after release the block waits for a new start.

Structure
REQ-032 A shared package seq_pkg SHALL hold the state enum (IDLE, SEND) and the constants PAT_W=16, LEN_W=5 and CNT_W=8.
REQ-033 The h/exp_y/match_cnt logic SHALL be a sub-module seq100_ref_chk (inputs clk, rst_n, clr, x, x_valid), instantiated once.

Verification
REQ-034 Case 1: pattern=16'h0009, len=6, repeat_en=0 (stream 1,0,0,1,0,0) -> exp_y high in cycles 4 and 7 after start; done in cycle 7; match_cnt=2.
REQ-035 Case 2: pattern=16'h0001, len=3, repeat_en=1, stop after 9 emitted bits -> exp_y every 3rd cycle; match_cnt=3; no done pulse.
REQ-036 Case 3: pattern=16'h0004, len=3, repeat_en=1 (stream 0,0,1, wrapping) -> first match spans the wrap, in cycle 5 after start; match_cnt=1 after 2 loops.
REQ-037 Case 4: start with len=0 -> busy stays 0, x_valid stays 0; start with len=20 -> 16 bits emitted, then done.
REQ-038 Case 5: rst_n pulsed low mid-SEND -> all outputs 0 asynchronously; a start reissued while busy is ignored.
REQ-039 Case 6: stop coincident with the last bit (repeat_en=0) -> IDLE, done never asserted.
